// File: rtl/rolling_variance_engine.sv
// Per-channel rolling mean / population variance over a 2**WINDOW_LOG2 sample window
// of top-of-book mid prices. Stage 1 updates ring and running sums; stage 2 derives results.
module rolling_variance_engine #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_STOCKS  = 4,
   parameter int WINDOW_LOG2 = 5,
   parameter int FRAC_BITS   = 16
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset_n,
   input  logic                                  i_valid,
   input  logic [$clog2(NUM_STOCKS)-1:0]         i_stock_id,
   input  logic [DATA_WIDTH-1:0]                 i_best_ask,
   input  logic [DATA_WIDTH-1:0]                 i_best_bid,
   input  logic                                  i_clear,
   output logic                                  o_valid,
   output logic [$clog2(NUM_STOCKS)-1:0]         o_stock_id,
   output logic [DATA_WIDTH-1:0]                 o_mid_price,
   output logic [DATA_WIDTH+FRAC_BITS-1:0]       o_mean,
   output logic [2*DATA_WIDTH+FRAC_BITS-1:0]     o_variance,
   output logic                                  o_window_full,
   output logic                                  o_drop
);

   localparam int SW    = $clog2(NUM_STOCKS);
   localparam int N     = 1 << WINDOW_LOG2;
   localparam int CW    = WINDOW_LOG2 + 1;
   localparam int S1W   = DATA_WIDTH + WINDOW_LOG2;
   localparam int S2W   = 2*DATA_WIDTH + WINDOW_LOG2;
   localparam int MW    = DATA_WIDTH + WINDOW_LOG2 + FRAC_BITS;
   localparam int VW    = 2*DATA_WIDTH + 2*WINDOW_LOG2 + FRAC_BITS;
   localparam int MEANW = DATA_WIDTH + FRAC_BITS;
   localparam int VARW  = 2*DATA_WIDTH + FRAC_BITS;
   localparam logic [CW-1:0] N_CNT = CW'(N);

   logic [DATA_WIDTH-1:0]  r_ring  [NUM_STOCKS][N];
   logic [WINDOW_LOG2-1:0] r_wptr  [NUM_STOCKS];
   logic [CW-1:0]          r_count [NUM_STOCKS];
   logic [S1W-1:0]         r_s1    [NUM_STOCKS];
   logic [S2W-1:0]         r_s2    [NUM_STOCKS];

   logic                   r_p1_valid;
   logic [SW-1:0]          r_p1_id;
   logic [DATA_WIDTH-1:0]  r_p1_mid;
   logic [S1W-1:0]         r_p1_s1;
   logic [S2W-1:0]         r_p1_s2;
   logic                   r_p1_full;

   logic                   r_out_valid;
   logic [SW-1:0]          r_out_id;
   logic [DATA_WIDTH-1:0]  r_out_mid;
   logic [MEANW-1:0]       r_out_mean;
   logic [VARW-1:0]        r_out_var;
   logic                   r_out_full;
   logic                   r_drop;

   logic [DATA_WIDTH:0]    w_mid_sum;
   logic [DATA_WIDTH-1:0]  w_mid;
   logic [DATA_WIDTH-1:0]  w_old;
   logic                   w_both_empty;
   logic                   w_accept;
   logic                   w_drop;
   logic [WINDOW_LOG2-1:0] w_ptr;
   logic [CW-1:0]          w_cnt;
   logic [CW-1:0]          w_cnt_next;
   logic [S1W-1:0]         w_s1_next;
   logic [S2W-1:0]         w_s2_next;
   logic [VW-1:0]          w_n_s2;
   logic [VW-1:0]          w_s1_sq;
   logic [VW-1:0]          w_var_diff;

   // Stage 1 combinational: mid price, evicted entry and updated channel sums.
   always_comb begin
      w_mid_sum    = {1'b0, i_best_ask} + {1'b0, i_best_bid};
      w_both_empty = (i_best_ask == '0) && (i_best_bid == '0);
      if (i_best_ask == '0) begin
         w_mid = i_best_bid;
      end else if (i_best_bid == '0) begin
         w_mid = i_best_ask;
      end else begin
         w_mid = w_mid_sum[DATA_WIDTH:1];
      end
      w_accept   = i_valid && !i_clear && !w_both_empty;
      w_drop     = i_valid && !i_clear && w_both_empty;
      w_ptr      = r_wptr[i_stock_id];
      w_old      = r_ring[i_stock_id][w_ptr];
      w_cnt      = r_count[i_stock_id];
      if (w_cnt < N_CNT) begin
         w_cnt_next = w_cnt + CW'(1);
      end else begin
         w_cnt_next = w_cnt;
      end
      // Modular arithmetic is exact: the true updated sums always fit their widths.
      w_s1_next = r_s1[i_stock_id] + S1W'(w_mid) - S1W'(w_old);
      w_s2_next = r_s2[i_stock_id] + S2W'(w_mid) * S2W'(w_mid)
                - S2W'(w_old) * S2W'(w_old);
   end

   // Channel state: ring, pointer, fill count and running sums.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            for (int k = 0; k < N; k++) begin
               r_ring[s][k] <= '0;
            end
            r_wptr[s]  <= '0;
            r_count[s] <= '0;
            r_s1[s]    <= '0;
            r_s2[s]    <= '0;
         end
      end else if (i_clear) begin
         for (int k = 0; k < N; k++) begin
            r_ring[i_stock_id][k] <= '0;
         end
         r_wptr[i_stock_id]  <= '0;
         r_count[i_stock_id] <= '0;
         r_s1[i_stock_id]    <= '0;
         r_s2[i_stock_id]    <= '0;
      end else if (w_accept) begin
         r_ring[i_stock_id][w_ptr] <= w_mid;
         r_wptr[i_stock_id]        <= w_ptr + WINDOW_LOG2'(1);
         r_count[i_stock_id]       <= w_cnt_next;
         r_s1[i_stock_id]          <= w_s1_next;
         r_s2[i_stock_id]          <= w_s2_next;
      end else begin
         r_wptr[i_stock_id] <= w_ptr;
      end
   end

   // Stage 1 pipeline register and the drop pulse.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_p1_valid <= 1'b0;
         r_p1_id    <= '0;
         r_p1_mid   <= '0;
         r_p1_s1    <= '0;
         r_p1_s2    <= '0;
         r_p1_full  <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_p1_valid <= w_accept;
         r_drop     <= w_drop;
         if (w_accept) begin
            r_p1_id   <= i_stock_id;
            r_p1_mid  <= w_mid;
            r_p1_s1   <= w_s1_next;
            r_p1_s2   <= w_s2_next;
            r_p1_full <= (w_cnt_next == N_CNT);
         end else begin
            r_p1_id   <= r_p1_id;
         end
      end
   end

   // Stage 2 combinational: N*S2 - S1^2, clamped at zero.
   always_comb begin
      w_n_s2  = VW'(r_p1_s2) << WINDOW_LOG2;
      w_s1_sq = VW'(r_p1_s1) * VW'(r_p1_s1);
      if (w_n_s2 >= w_s1_sq) begin
         w_var_diff = w_n_s2 - w_s1_sq;
      end else begin
         w_var_diff = '0;
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_out_mid   <= '0;
         r_out_mean  <= '0;
         r_out_var   <= '0;
         r_out_full  <= 1'b0;
      end else begin
         r_out_valid <= r_p1_valid;
         if (r_p1_valid) begin
            r_out_id   <= r_p1_id;
            r_out_mid  <= r_p1_mid;
            r_out_mean <= MEANW'((MW'(r_p1_s1) << FRAC_BITS) >> WINDOW_LOG2);
            r_out_var  <= VARW'((w_var_diff << FRAC_BITS) >> (2*WINDOW_LOG2));
            r_out_full <= r_p1_full;
         end else begin
            r_out_id   <= r_out_id;
         end
      end
   end

   assign o_valid       = r_out_valid;
   assign o_stock_id    = r_out_id;
   assign o_mid_price   = r_out_mid;
   assign o_mean        = r_out_mean;
   assign o_variance    = r_out_var;
   assign o_window_full = r_out_full;
   assign o_drop        = r_drop;

endmodule

// File: doc/rolling_variance_engine.md
ROLLING_VARIANCE_ENGINE -- requirements
Module: rolling_variance_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, price width in integer ticks.
REQ-002 SHALL have parameter NUM_STOCKS, default 4, number of independent channels (>=2, power of two).
REQ-003 SHALL have parameter WINDOW_LOG2, default 5, window depth N = 2**WINDOW_LOG2 samples per stock.
REQ-004 SHALL have parameter FRAC_BITS, default 16, fractional bits of o_mean and o_variance.
REQ-005 SHALL have i_clk  input  1  the single clock; all state on its rising edge.
REQ-006 SHALL have i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have i_valid  input  1  quote sample present this cycle.
REQ-008 SHALL have i_stock_id  input  $clog2(NUM_STOCKS)  channel of sample or clear.
REQ-009 SHALL have i_best_ask, i_best_bid  input  DATA_WIDTH each  top-of-book prices; 0 = side empty.
REQ-010 SHALL have i_clear  input  1  flush state of channel i_stock_id.
REQ-011 SHALL have o_valid  output  1  result present.
REQ-012 SHALL have o_stock_id  output  $clog2(NUM_STOCKS)  channel of result.
REQ-013 SHALL have o_mid_price  output  DATA_WIDTH  sample accepted for that result.
REQ-014 SHALL have o_mean  output  DATA_WIDTH+FRAC_BITS  window mean, unsigned Q(DATA_WIDTH).FRAC_BITS.
REQ-015 SHALL have o_variance  output  2*DATA_WIDTH+FRAC_BITS  window population variance, unsigned Q(2*DATA_WIDTH).FRAC_BITS.
REQ-016 SHALL have o_window_full  output  1  N samples accepted for o_stock_id since reset/clear.
REQ-017 SHALL have o_drop  output  1  one-cycle pulse: sample rejected (both sides empty).

Function
REQ-018 Mid price SHALL be: both nonzero -> floor((ask+bid)/2) computed at DATA_WIDTH+1 bits; ask==0 -> bid; bid==0 -> ask.
REQ-019 Both sides 0 with i_valid SHALL leave all channel state unchanged, assert o_drop at cycle N+1, never assert o_valid.
REQ-020 Per channel SHALL hold an N-entry sample ring, a write pointer, fill count (saturating at N), S1 sum (DATA_WIDTH+WINDOW_LOG2 bits), S2 sum of squares (2*DATA_WIDTH+WINDOW_LOG2 bits); write address generated internally.
REQ-021 Accepted sample at cycle N SHALL, at edge N+1: read evicted entry at pointer, write new mid there, S1 += new - old, S2 += new^2 - old^2, pointer += 1 modulo N, count += 1 if < N.
REQ-022 Stage 2 SHALL register o_valid, o_stock_id, o_mid_price, o_window_full and results at edge N+2; latency exactly 2 cycles, throughput one sample per cycle, no backpressure.
REQ-023 o_mean SHALL equal (S1 << FRAC_BITS) >> WINDOW_LOG2, floor.
REQ-024 o_variance SHALL equal ((N*S2 - S1^2) << FRAC_BITS) >> (2*WINDOW_LOG2), floor, intermediate at full 2*DATA_WIDTH+2*WINDOW_LOG2+FRAC_BITS width, never negative.
REQ-025 Before full, empty ring slots SHALL count as 0 and results still be output with o_window_full=0.
REQ-026 Back-to-back samples on the same channel SHALL see the previous sample's updated sums with no stall or loss.
REQ-027 Channels SHALL be fully independent; sample on one channel SHALL not alter another.
REQ-028 i_clear SHALL zero that channel's ring, sums, pointer, count at next edge; i_clear with i_valid SHALL clear and discard the sample (no o_valid, no o_drop).
REQ-029 Pointer wrap N-1 -> 0 SHALL evict the oldest sample exactly.

Reset
REQ-030 i_reset_n low SHALL immediately zero all rings, sums, pointers, counts, pipeline registers and all outputs.
REQ-031 Samples in flight at reset SHALL be lost; first sample after release SHALL behave as on a fresh channel.

Verification (WINDOW_LOG2=2, FRAC_BITS=8, DATA_WIDTH=32)
REQ-032 Stock 0 mids 1,2,3,4 (ask=bid) on consecutive cycles -> 4th result two cycles later: o_mean=640, o_variance=320, o_window_full=1; first three o_window_full=0.
REQ-033 Then mid 5 on stock 0 -> window 2,3,4,5: o_mean=896, o_variance=320 (wrap eviction).
REQ-034 Four samples ask=bid=10 on stock 1 interleaved with stock 0 traffic -> stock 1 o_variance=0, o_mean=2560; stock 0 results unaffected.
REQ-035 ask=0,bid=100 -> o_mid_price=100; ask=0,bid=0 -> o_drop pulse, no o_valid, sums unchanged.
REQ-036 i_clear on stock 0 after full window, then mid 8 -> o_mean=512, o_variance=3072, o_window_full=0; reset asserted mid-stream -> all outputs 0 immediately.
